// File: rtl/y86_ins_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : y86_ins_encoder_if
//  Description : Handshake and byte-write bus for the Y86 instruction encoder.
//                Groups the decoded-instruction input handshake with the
//                byte-wide instruction-memory write port.
//                  in_valid/in_ready      instruction handshake
//                  in_icode/in_ifun       instruction and function codes
//                  in_rA/in_rB            register fields
//                  in_valC                constant / displacement / target
//                  mem_we/mem_addr/mem_data  registered byte write port
//                modport master : instruction producer and memory sink
//                modport slave  : the encoder
//  Revision    : 1.0 - initial release
// ============================================================================
interface y86_ins_encoder_if #(
  parameter int ADDR_W = 64
) ();

  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_icode;
  logic [3:0]        in_ifun;
  logic [3:0]        in_rA;
  logic [3:0]        in_rB;
  logic [63:0]       in_valC;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;

  modport master (
    output in_valid, in_icode, in_ifun, in_rA, in_rB, in_valC,
    input  in_ready, mem_we, mem_addr, mem_data
  );

  modport slave (
    input  in_valid, in_icode, in_ifun, in_rA, in_rB, in_valC,
    output in_ready, mem_we, mem_addr, mem_data
  );

endinterface
`default_nettype wire

// File: rtl/y86_ins_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : y86_ins_encoder
//  Description : Serialises one decoded Y86 instruction per handshake into
//                the byte encoding read back by the fetch stage, writing one
//                byte per clock into instruction memory. A write pointer
//                advances past every encoded instruction.
//  Ports       : clock        rising-edge clock
//                reset_n      asynchronous active-low reset
//                base_load    load write pointer from base_addr (IDLE only)
//                base_addr    new write-pointer value
//                bus          y86_ins_encoder_if.slave (handshake + byte port)
//                next_addr    current write pointer
//                busy         multi-byte emission in progress
//                err_icode    sticky: instruction rejected as invalid
//                err_overflow sticky: encoding would run past MEM_SIZE-1
//  Options     : REG_CHECK_EN - when defined, an instruction whose required
//                register field is 4'hF is rejected like an invalid icode.
//  Revision    : 1.0 - initial release
// ============================================================================
module y86_ins_encoder #(
  parameter int MEM_SIZE = 128,
  parameter int ADDR_W   = 64
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              base_load,
  input  logic [ADDR_W-1:0] base_addr,
  y86_ins_encoder_if.slave  bus,
  output logic [ADDR_W-1:0] next_addr,
  output logic              busy,
  output logic              err_icode,
  output logic              err_overflow
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  // Limit held one bit wider than the pointer so pointer+len cannot wrap.
  localparam logic [ADDR_W:0] C_MEM_LIMIT = (ADDR_W+1)'(MEM_SIZE);

  state_t            state_q;
  logic [ADDR_W-1:0] next_addr_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_data_q;
  logic [71:0]       tail_q;      // bytes 1..len-1, lowest byte emitted next
  logic [3:0]        rem_q;       // bytes still to emit in EMIT
  logic              err_icode_q;
  logic              err_ovf_q;

  logic [3:0]        len_d;
  logic [71:0]       tail_d;
  logic              fields_ok;
  logic              overflow;
  logic [ADDR_W:0]   end_addr;
  logic              ready;

  // --------------------------------------------------------------------------
  // Encoding length and field validity
  // --------------------------------------------------------------------------
  always_comb begin
    len_d = 4'd0;
    case (bus.in_icode)
      4'h0, 4'h1, 4'h9:       len_d = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB: len_d = 4'd2;
      4'h3, 4'h4, 4'h5:       len_d = 4'd10;
      4'h7, 4'h8:             len_d = 4'd9;
      default:                len_d = 4'd0;
    endcase
  end

`ifdef REG_CHECK_EN
  logic need_ra;
  logic need_rb;

  always_comb begin
    need_ra = 1'b0;
    need_rb = 1'b0;
    case (bus.in_icode)
      4'h2, 4'h4, 4'h5, 4'h6: begin
        need_ra = 1'b1;
        need_rb = 1'b1;
      end
      4'h3:       need_rb = 1'b1;
      4'hA, 4'hB: need_ra = 1'b1;
      default: begin
        need_ra = 1'b0;
        need_rb = 1'b0;
      end
    endcase
  end

  assign fields_ok = (len_d != 4'd0)
                   && !(need_ra && (bus.in_rA == 4'hF))
                   && !(need_rb && (bus.in_rB == 4'hF));
`else
  assign fields_ok = (len_d != 4'd0);
`endif

  assign end_addr = {1'b0, next_addr_q} + {{(ADDR_W-3){1'b0}}, len_d};
  assign overflow = (end_addr > C_MEM_LIMIT);

  // Bytes following byte 0, packed little-end first so EMIT just shifts.
  always_comb begin
    tail_d = 72'd0;
    case (len_d)
      4'd2:    tail_d = {64'd0, bus.in_rA, bus.in_rB};
      4'd10:   tail_d = {bus.in_valC, bus.in_rA, bus.in_rB};
      4'd9:    tail_d = {8'd0, bus.in_valC};
      default: tail_d = 72'd0;
    endcase
  end

  assign ready = (state_q == ST_IDLE) && !base_load;

  // --------------------------------------------------------------------------
  // Controller and registered write port
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      next_addr_q <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= 8'd0;
      tail_q      <= 72'd0;
      rem_q       <= 4'd0;
      err_icode_q <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          mem_we_q <= 1'b0;
          if (base_load) begin
            next_addr_q <= base_addr;
          end else if (bus.in_valid) begin
            // Rejected instructions are still consumed; pointer is untouched.
            if (!fields_ok) begin
              err_icode_q <= 1'b1;
            end else if (overflow) begin
              err_ovf_q <= 1'b1;
            end else begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= next_addr_q;
              mem_data_q  <= {bus.in_icode, bus.in_ifun};
              next_addr_q <= next_addr_q + ADDR_W'(1);
              tail_q      <= tail_d;
              rem_q       <= len_d - 4'd1;
              if (len_d != 4'd1) begin
                state_q <= ST_EMIT;
              end
            end
          end
        end
        ST_EMIT: begin
          mem_we_q    <= 1'b1;
          mem_addr_q  <= next_addr_q;
          mem_data_q  <= tail_q[7:0];
          tail_q      <= {8'd0, tail_q[71:8]};
          next_addr_q <= next_addr_q + ADDR_W'(1);
          rem_q       <= rem_q - 4'd1;
          if (rem_q == 4'd1) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready = ready;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_data = mem_data_q;
  assign next_addr    = next_addr_q;
  assign busy         = (state_q == ST_EMIT);
  assign err_icode    = err_icode_q;
  assign err_overflow = err_ovf_q;

endmodule
`default_nettype wire
